// File: rtl/carry_chain_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one CHUNK-bit ripple
// carry slice. It handles one chunk per cycle, LSB chunk first, and keeps the
// chain carry in a register between chunks.
module carry_chain_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             CI_INIT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CO,
    output logic             OV,
    output logic             BUSY
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             accept;
    logic             last;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] res;
    logic             rip_c;
    logic             rip_s;
    logic             chunk_co;
    logic             chunk_cmsb;

    // State register
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic and handshake decode
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        last    = (cnt == LAST_CHUNK);
        case (state)
            IDLE: begin
                accept = IN_VALID;
                if (IN_VALID) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select the operand slice for the chunk currently in the chain
    always_comb begin
        ca = '0;
        cb = '0;
        for (int k = 0; k < int'(NCHUNK); k++) begin
            if (cnt == CW'(k)) begin
                ca = opa[k*CHUNK +: CHUNK];
                cb = opb[k*CHUNK +: CHUNK];
            end
        end
    end

    // CARRY-cell ripple: S = a^b, DI = a, O = S^ci, co = S ? ci : DI
    always_comb begin
        res        = '0;
        rip_c      = cy;
        rip_s      = 1'b0;
        chunk_cmsb = 1'b0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            rip_s  = ca[i] ^ cb[i];
            res[i] = rip_s ^ rip_c;
            if (i == int'(CHUNK) - 1) begin
                chunk_cmsb = rip_c;
            end
            rip_c = rip_s ? rip_c : ca[i];
        end
        chunk_co = rip_c;
    end

    // Handshake/status outputs, registered from the next state
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            IN_READY  <= 1'b1;
            BUSY      <= 1'b0;
            OUT_VALID <= 1'b0;
        end else begin
            IN_READY  <= (state_d == IDLE);
            BUSY      <= (state_d != IDLE);
            OUT_VALID <= (state_d == DONE);
        end
    end

    // Operand capture, chunk sequencing and result accumulation
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            opa <= '0;
            opb <= '0;
            cy  <= 1'b0;
            cnt <= '0;
            SUM <= '0;
            CO  <= 1'b0;
            OV  <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1, so the fabric carry is forced to 1
            opa <= A;
            opb <= SUB ? ~B : B;
            cy  <= SUB ? 1'b1 : CI_INIT;
            cnt <= '0;
        end else if (state == RUN) begin
            cy <= chunk_co;
            for (int k = 0; k < int'(NCHUNK); k++) begin
                if (cnt == CW'(k)) begin
                    SUM[k*CHUNK +: CHUNK] <= res;
                end
            end
            if (last) begin
                CO <= chunk_co;
                OV <= chunk_cmsb ^ chunk_co;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_carry_chain_seq.sv
// Directed bench for carry_chain_seq: an 8-bit/4-bit-chunk instance and a
// 32-bit/4-bit-chunk instance that share operand and control inputs.
module tb_carry_chain_seq;

    logic        clk;
    logic        clr;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        ci;
    logic        ordy;
    logic        iv8;
    logic        iv32;

    logic        ir8, vld8, co8, ovf8, busy8;
    logic [7:0]  sum8;
    logic        ir32, vld32, co32, ovf32, busy32;
    logic [31:0] sum32;

    logic        sel;
    logic        obs_ir, obs_vld, obs_co, obs_ovf, obs_busy;
    logic [31:0] obs_sum;

    int checks = 0;
    int errors = 0;

    carry_chain_seq #(.WIDTH(8), .CHUNK(4)) dut8 (
        .C(clk), .CLR(clr), .IN_VALID(iv8), .IN_READY(ir8),
        .A(a[7:0]), .B(b[7:0]), .SUB(sub), .CI_INIT(ci),
        .OUT_VALID(vld8), .OUT_READY(ordy), .SUM(sum8),
        .CO(co8), .OV(ovf8), .BUSY(busy8)
    );

    carry_chain_seq #(.WIDTH(32), .CHUNK(4)) dut32 (
        .C(clk), .CLR(clr), .IN_VALID(iv32), .IN_READY(ir32),
        .A(a), .B(b), .SUB(sub), .CI_INIT(ci),
        .OUT_VALID(vld32), .OUT_READY(ordy), .SUM(sum32),
        .CO(co32), .OV(ovf32), .BUSY(busy32)
    );

    // Route the selected instance to a common set of observation signals
    always_comb begin
        obs_ir   = sel ? ir32   : ir8;
        obs_vld  = sel ? vld32  : vld8;
        obs_co   = sel ? co32   : co8;
        obs_ovf  = sel ? ovf32  : ovf8;
        obs_busy = sel ? busy32 : busy8;
        obs_sum  = sel ? sum32  : {24'h0, sum8};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Issue one operation, check latency, result, optional backpressure hold and handshake
    task automatic run_op(input logic is32, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic tsub, input logic tci, input logic [31:0] esum,
                          input logic eco, input logic eov, input int hold, input string tag);
        int edges;
        int lat;
        sel = is32;
        lat = is32 ? 9 : 3;
        a   = ta;
        b   = tb_v;
        sub = tsub;
        ci  = tci;
        #0;
        check({tag, "/in_ready"}, 32'(obs_ir), 32'd1);
        if (is32) iv32 = 1'b1;
        else      iv8  = 1'b1;
        @(posedge clk);
        #1;
        iv8  = 1'b0;
        iv32 = 1'b0;
        a    = ~ta;
        b    = ~tb_v;
        sub  = ~tsub;
        ci   = ~tci;
        check({tag, "/busy_run"}, {31'h0, obs_busy, obs_ir}, 32'd2);
        edges = 1;
        while (!obs_vld && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "/latency"}, 32'(edges), 32'(lat));
        check({tag, "/sum"}, obs_sum, esum);
        check({tag, "/co_ov"}, {30'h0, obs_co, obs_ovf}, {30'h0, eco, eov});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "/hold_sum"}, obs_sum, esum);
            check({tag, "/hold_flags"}, {28'h0, obs_vld, obs_ir, obs_co, obs_ovf},
                  {28'h0, 1'b1, 1'b0, eco, eov});
        end
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        check({tag, "/release"}, {29'h0, obs_vld, obs_ir, obs_busy}, 32'd2);
    endtask

    initial begin
        clr  = 1'b1;
        a    = '0;
        b    = '0;
        sub  = 1'b0;
        ci   = 1'b0;
        ordy = 1'b0;
        iv8  = 1'b0;
        iv32 = 1'b0;
        sel  = 1'b0;
        #12;
        check("reset8", {29'h0, ir8, vld8, busy8}, 32'd4);
        check("reset8_res", {22'h0, sum8, co8, ovf8}, 32'd0);
        check("reset32", {29'h0, ir32, vld32, busy32}, 32'd4);
        check("reset32_sum", sum32, 32'd0);
        clr = 1'b0;
        @(posedge clk);
        #1;

        run_op(1'b0, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 0, "add_ff_01");
        run_op(1'b0, 32'h05, 32'h07, 1'b1, 1'b0, 32'hFE, 1'b0, 1'b0, 0, "sub_5_7");
        run_op(1'b0, 32'h07, 32'h05, 1'b1, 1'b0, 32'h02, 1'b1, 1'b0, 0, "sub_7_5");
        run_op(1'b0, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 0, "ovf_pos");
        run_op(1'b0, 32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 0, "ovf_neg");
        run_op(1'b0, 32'h0F, 32'h00, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 0, "ci_cross");
        run_op(1'b0, 32'h0F, 32'h00, 1'b1, 1'b1, 32'h0F, 1'b1, 1'b0, 0, "ci_ignored");
        run_op(1'b0, 32'h3C, 32'hA5, 1'b0, 1'b1, 32'hE2, 1'b0, 1'b0, 5, "backpressure");
        run_op(1'b1, 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 0,
               "w32_sub_ovf");

        // Abort a 32-bit operation mid-RUN with an asynchronous clear
        sel  = 1'b1;
        a    = 32'h12345678;
        b    = 32'h11111111;
        sub  = 1'b0;
        ci   = 1'b0;
        iv32 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("clr_pre_busy", {31'h0, busy32}, 32'd1);
        clr = 1'b1;
        #1;
        check("clr_flags", {27'h0, ir32, vld32, busy32, co32, ovf32}, 32'h10);
        check("clr_sum", sum32, 32'd0);
        #2;
        clr = 1'b0;
        @(posedge clk);
        #1;
        run_op(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 0,
               "w32_after_clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
